// File: rtl/cpu_core_apb.sv
// Multicycle CPU core: 8 x DATA_W register file, ALU, PC/IR and a control FSM acting as APB master.
// Define CPU_RETIRE_CNT_EN to build the 32-bit retired-instruction counter; otherwise retired is 0.
module cpu_core_apb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       retired
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_ST   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_JR   = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd15;

    // S_RESET holds the bus idle while reset is applied; fetch starts on the first edge after release.
    typedef enum logic [2:0] {
        S_RESET,
        F_SETUP,
        F_ACCESS,
        EXEC,
        M_SETUP,
        M_ACCESS,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_maddr;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [8];
    logic              r_halted;
    logic              r_fault;

    logic [3:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic signed [5:0] w_imm6;
    logic [DATA_W-1:0] w_imm_d;
    logic [ADDR_W-1:0] w_imm_a;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_we;
    logic              w_ir_ld;
    logic              w_maddr_ld;
    logic              w_retire;
    logic              w_is_mem;

    assign w_op    = r_ir[15:12];
    assign w_rd    = r_ir[11:9];
    assign w_rs1   = r_ir[8:6];
    assign w_rs2   = r_ir[5:3];
    assign w_imm6  = r_ir[5:0];
    assign w_imm_d = DATA_W'(w_imm6);
    assign w_imm_a = ADDR_W'(w_imm6);

    // r0 is hard-wired to zero on the read side; writes to it are dropped below.
    assign w_rd_val  = (w_rd  == 3'd0) ? '0 : r_regs[w_rd];
    assign w_rs1_val = (w_rs1 == 3'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 3'd0) ? '0 : r_regs[w_rs2];
    assign w_sum     = w_rs1_val + w_imm_d;
    assign w_pc_inc  = r_pc + ADDR_W'(1);

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_we       = 1'b0;
        w_wdata    = '0;
        w_ir_ld    = 1'b0;
        w_maddr_ld = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_RESET:  w_next = F_SETUP;
            F_SETUP:  w_next = F_ACCESS;
            F_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        w_next = S_FAULT;
                    end else begin
                        w_ir_ld = 1'b1;
                        w_next  = EXEC;
                    end
                end
            end
            EXEC: begin
                w_next    = F_SETUP;
                w_pc_next = w_pc_inc;
                w_retire  = 1'b1;
                case (w_op)
                    OP_ADD: begin
                        w_we    = 1'b1;
                        w_wdata = w_rs1_val + w_rs2_val;
                    end
                    OP_SUB: begin
                        w_we    = 1'b1;
                        w_wdata = w_rs1_val - w_rs2_val;
                    end
                    OP_ADDI: begin
                        w_we    = 1'b1;
                        w_wdata = w_sum;
                    end
                    OP_LD, OP_ST: begin
                        // Memory ops retire and advance PC only once the data transfer completes.
                        w_maddr_ld = 1'b1;
                        w_pc_next  = r_pc;
                        w_retire   = 1'b0;
                        w_next     = M_SETUP;
                    end
                    OP_BEQ: begin
                        if (w_rd_val == w_rs1_val) begin
                            w_pc_next = w_pc_inc + w_imm_a;
                        end
                    end
                    OP_JR:   w_pc_next = ADDR_W'(w_rs1_val);
                    OP_HALT: begin
                        w_pc_next = r_pc;
                        w_next    = S_HALT;
                    end
                    default: ;
                endcase
            end
            M_SETUP:  w_next = M_ACCESS;
            M_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        w_next = S_FAULT;
                    end else begin
                        w_we      = (w_op == OP_LD);
                        w_wdata   = prdata;
                        w_pc_next = w_pc_inc;
                        w_retire  = 1'b1;
                        w_next    = F_SETUP;
                    end
                end
            end
            S_HALT:   w_next = S_HALT;
            S_FAULT:  w_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RESET;
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state  <= w_next;
            r_pc     <= w_pc_next;
            r_halted <= (w_next == S_HALT);
            r_fault  <= (w_next == S_FAULT);
            if (w_we && (w_rd != 3'd0)) begin
                r_regs[w_rd] <= w_wdata;
            end
        end
    end

    // IR and data address only matter in states that load them first, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_ir_ld) begin
            r_ir <= prdata[15:0];
        end
        if (w_maddr_ld) begin
            r_maddr <= ADDR_W'(w_sum);
        end
    end

`ifdef CPU_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    logic w_unused_retire;

    assign w_unused_retire = w_retire;
    assign retired         = '0;
`endif

    // Bus outputs decode from registered state only, so they hold steady through the whole transfer.
    assign w_is_mem = (r_state == M_SETUP) || (r_state == M_ACCESS);
    assign psel     = (r_state == F_SETUP) || (r_state == F_ACCESS) || w_is_mem;
    assign penable  = (r_state == F_ACCESS) || (r_state == M_ACCESS);
    assign paddr    = w_is_mem ? r_maddr : (psel ? r_pc : '0);
    assign pwrite   = w_is_mem && (w_op == OP_ST);
    assign pwdata   = pwrite ? w_rd_val : '0;
    assign pc       = r_pc;
    assign halted   = r_halted;
    assign fault    = r_fault;

endmodule

// File: tb/tb_cpu_core_apb.sv
// Scoreboard bench for cpu_core_apb: an ISA-level model predicts every APB transfer and final state.
module tb_cpu_core_apb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              fault;
    logic [31:0]       retired;

    cpu_core_apb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .pc(pc), .halted(halted), .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
    } xfer_t;

    logic [15:0] mem [65536];
    logic [15:0] mm  [65536];
    xfer_t       exp_q [$];
    int          dly_q [$];
    bit          err_q [$];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    bit          mon_en = 1'b0;

    logic [15:0] m_pc;
    logic [15:0] m_regs [8];
    int          m_ret;
    int          m_cyc;
    bit          m_halted;
    bit          m_fault;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int lo6);
        enc = {4'(op), 3'(rd), 3'(rs1), 6'(lo6)};
    endfunction

    function automatic int pick(input int mode, input bit data);
        case (mode)
            1:       pick = data ? 2 : 0;
            2:       pick = int'($urandom_range(0, 2));
            3:       pick = 1;
            default: pick = 0;
        endcase
    endfunction

    // Instruction-level reference: executes the program and records the bus transfers it implies.
    task automatic run_model(input int mode, input bit err, input int max_instr);
        logic [15:0] ir, a, b, se, ea, res;
        logic [3:0]  op;
        int          rd, rs1, rs2, d;
        bit          done, wb;
        m_pc = 16'h0; m_ret = 0; m_cyc = 0; m_halted = 1'b0; m_fault = 1'b0; done = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 16'h0;
        for (int k = 0; k < max_instr && !done; k++) begin
            ir = mm[m_pc];
            d  = pick(mode, 1'b0);
            exp_q.push_back('{addr: m_pc, wr: 1'b0, wdata: 16'h0});
            dly_q.push_back(d); err_q.push_back(1'b0);
            m_cyc += 3 + d;
            op = ir[15:12]; rd = int'(ir[11:9]); rs1 = int'(ir[8:6]); rs2 = int'(ir[5:3]);
            se = {{10{ir[5]}}, ir[5:0]};
            a = m_regs[rs1]; b = m_regs[rs2]; ea = a + se;
            wb = 1'b0; res = 16'h0;
            case (op)
                4'd0: begin res = a + b;  wb = 1'b1; m_pc = m_pc + 16'd1; end
                4'd1: begin res = a - b;  wb = 1'b1; m_pc = m_pc + 16'd1; end
                4'd2: begin res = a + se; wb = 1'b1; m_pc = m_pc + 16'd1; end
                4'd3, 4'd4: begin
                    d = pick(mode, 1'b1);
                    exp_q.push_back('{addr: ea, wr: (op == 4'd4), wdata: (op == 4'd4) ? m_regs[rd] : 16'h0});
                    dly_q.push_back(d); err_q.push_back(err);
                    m_cyc += 2 + d;
                    if (err) begin
                        m_fault = 1'b1; done = 1'b1;
                    end else begin
                        if (op == 4'd3) begin res = mm[ea]; wb = 1'b1; end
                        else mm[ea] = m_regs[rd];
                        m_pc = m_pc + 16'd1;
                    end
                end
                4'd5:  m_pc = (m_regs[rd] == a) ? m_pc + 16'd1 + se : m_pc + 16'd1;
                4'd6:  m_pc = a;
                4'd15: begin m_halted = 1'b1; done = 1'b1; end
                default: m_pc = m_pc + 16'd1;
            endcase
            if (wb && rd != 0) m_regs[rd] = res;
            if (!m_fault) m_ret++;
        end
    endtask

    // APB slave: per-transfer wait states and error flags come from the model's queues.
    initial begin
        int cnt;
        bit cur_err;
        cnt = 0; cur_err = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(negedge clk);
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = 16'($urandom);
            if (reset) begin
                cnt = 0;
            end else if (psel && !penable) begin
                cnt     = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                cur_err = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
            end else if (psel && penable) begin
                if (cnt > 0) begin
                    cnt--;
                end else begin
                    pready  = 1'b1;
                    pslverr = cur_err;
                    if (pwrite && !cur_err) mem[paddr] = pwdata;
                    prdata = mem[paddr];
                end
            end
        end
    end

    // Monitor: every completed transfer is matched against the next expected one.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && psel && penable && pready) begin
                n_xfer++;
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL extra_xfer: addr %0h with no transfer expected", paddr);
                    end else begin
                        e = exp_q.pop_front();
                        check("paddr", 32'(paddr), 32'(e.addr));
                        check("pwrite", 32'(pwrite), 32'(e.wr));
                        if (e.wr) check("pwdata", 32'(pwdata), 32'(e.wdata));
                    end
                end
            end
        end
    end

    task automatic start_test(input int mode, input bit err, input int max_instr);
        reset = 1'b1; mon_en = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete(); dly_q.delete(); err_q.delete();
        mm = mem;
        run_model(mode, err, max_instr);
        mon_en = 1'b1;
        reset  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (halted || fault) break;
            cyc++;
        end
    endtask

    task automatic finish_checks(input int cyc);
        check("cycles", 32'(cyc), 32'(m_cyc));
        check("pc", 32'(pc), 32'(m_pc));
        check("halted", 32'(halted), 32'(m_halted));
        check("fault", 32'(fault), 32'(m_fault));
`ifdef CPU_RETIRE_CNT_EN
        check("retired", retired, 32'(m_ret));
`else
        check("retired", retired, 32'h0);
`endif
        check("xfers_left", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic gen_random(input int n);
        for (int k = 0; k < n; k++) begin
            int rd, rs1, rs2;
            rd = int'($urandom_range(0, 7)); rs1 = int'($urandom_range(0, 7)); rs2 = int'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       mem[k] = enc(0, rd, rs1, rs2 * 8);
                1:       mem[k] = enc(1, rd, rs1, rs2 * 8);
                4, 9:    mem[k] = enc(3, rd, rs1, int'($urandom_range(0, 63)));
                5:       mem[k] = enc(4, rd, 0, int'($urandom_range(32, 63)));
                6:       mem[k] = enc(5, rd, rs1, int'($urandom_range(0, 3)));
                7:       mem[k] = enc(int'($urandom_range(7, 14)), rd, rs1, int'($urandom_range(0, 63)));
                default: mem[k] = enc(2, rd, rs1, int'($urandom_range(0, 63)));
            endcase
        end
        for (int k = n; k < n + 5; k++) mem[k] = 16'hF000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, base, busy;
        bit  seen;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {27'h0, psel, penable, pwrite, halted, fault}, 32'h0);
        check("rst_paddr", 32'(paddr), 32'h0);
        check("rst_pwdata", 32'(pwdata), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_retired", retired, 32'h0);

        mem[0] = enc(2, 1, 0, 5); mem[1] = enc(2, 2, 0, -3); mem[2] = enc(0, 3, 1, 2 * 8); mem[3] = 16'hF000;
        start_test(0, 1'b0, 100);
        wait_done(cyc);
        check("basic_cycles", 32'(cyc), 32'd12);
        finish_checks(cyc);
        check("basic_r3", 32'(dut.r_regs[3]), 32'd2);

        mem[0] = enc(2, 1, 0, 1); mem[1] = enc(1, 1, 0, 1 * 8); mem[2] = enc(4, 1, 0, -1); mem[3] = 16'hF000;
        start_test(0, 1'b0, 100);
        wait_done(cyc);
        finish_checks(cyc);
        check("sub_wrap_mem", 32'(mem[16'hFFFF]), 32'h0000FFFF);

        mem[0] = enc(2, 1, 0, 13); mem[1] = enc(4, 1, 0, 10); mem[2] = enc(3, 2, 0, 10);
        mem[3] = enc(4, 2, 0, 11); mem[4] = 16'hF000;
        start_test(1, 1'b0, 100);
        wait_done(cyc);
        check("memwait_cycles", 32'(cyc), 32'd27);
        finish_checks(cyc);
        check("ld_st_mem", 32'(mem[11]), 32'd13);

        mem[0] = enc(2, 1, 0, 1); mem[1] = 16'h7000; mem[2] = 16'h8000; mem[3] = 16'h9000;
        mem[4] = enc(5, 1, 0, 5); mem[5] = enc(2, 4, 0, 9); mem[6] = enc(6, 0, 4, 0);
        mem[7] = 16'hF000; mem[8] = 16'hF000; mem[9] = enc(4, 4, 0, -2); mem[10] = 16'hF000;
        start_test(0, 1'b0, 100);
        wait_done(cyc);
        finish_checks(cyc);

        for (int k = 0; k < 4; k++) mem[k] = 16'h7000;
        mem[4] = enc(5, 1, 1, -1);
        start_test(0, 1'b0, 12);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0) break;
        end
        mon_en = 1'b0;
        check("loop_drained", 32'(exp_q.size()), 32'h0);
        check("loop_pc", 32'(pc), 32'd4);

        mem[0] = enc(2, 1, 0, 7); mem[1] = enc(2, 3, 0, 4); mem[2] = enc(3, 3, 0, 5); mem[3] = 16'hF000;
        start_test(0, 1'b1, 100);
        wait_done(cyc);
        finish_checks(cyc);
        check("fault_rd_kept", 32'(dut.r_regs[3]), 32'd4);
        check("fault_psel", 32'(psel), 32'h0);
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (psel) busy++;
        end
        check("fault_no_traffic", 32'(busy), 32'h0);
        check("fault_sticky", 32'(fault), 32'h1);

        mem[0] = enc(2, 1, 0, 9); mem[1] = enc(2, 2, 0, 3); mem[2] = enc(0, 3, 1, 2 * 8);
        mem[3] = enc(4, 3, 0, -4); mem[4] = 16'hF000;
        start_test(3, 1'b0, 100);
        base = n_xfer;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (n_xfer - base >= 2) break;
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (psel && penable) begin seen = 1'b1; break; end
        end
        check("rstmid_access_seen", 32'(seen), 32'h1);
        check("rstmid_r1_before", 32'(dut.r_regs[1]), 32'd9);
        reset = 1'b1; mon_en = 1'b0;
        @(negedge clk);
        check("rstmid_psel", {30'h0, psel, penable}, 32'h0);
        check("rstmid_pc", 32'(pc), 32'h0);
        check("rstmid_regs", {dut.r_regs[1], dut.r_regs[2]}, 32'h0);
        start_test(0, 1'b0, 100);
        wait_done(cyc);
        finish_checks(cyc);

        for (int t = 0; t < 6; t++) begin
            gen_random(20);
            start_test(2, 1'b0, 200);
            wait_done(cyc);
            finish_checks(cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
